sap_datapath: RTL and testbench

SAP_DATAPATH -- requirements
Module: sap_datapath

---
 rtl/sap_datapath.sv | 140 ++++++++++++++
 tb/tb_sap_datapath.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sap_datapath.sv
// SAP-1 style datapath: program counter, memory address register, 16x8 RAM,
// instruction register, A/B/C registers, ALU, output register and a shared W bus.
// The sequencer drives a 16-bit control word.
// This block decodes that word, resolves the bus and updates the registers.
module sap_datapath (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [15:0] con,
    output logic [3:0]  opcode,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [7:0]  prog_data,
    output logic [7:0]  out_reg,
    output logic [7:0]  wbus,
    output logic        carry,
    output logic        zero,
    output logic        bus_err
);

    typedef logic [7:0] ram_t [16];

    logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, eb, ec, eu, lb_n, lc_n, lo_n;
    logic [1:0] alu_op;

    assign cp     = con[15];
    assign ep     = con[14];
    assign lm_n   = con[13];
    assign ce_n   = con[12];
    assign li_n   = con[11];
    assign ei_n   = con[10];
    assign la_n   = con[9];
    assign ea     = con[8];
    assign eb     = con[7];
    assign ec     = con[6];
    assign alu_op = con[5:4];
    assign eu     = con[3];
    assign lb_n   = con[2];
    assign lc_n   = con[1];
    assign lo_n   = con[0];

    logic [3:0] pc_q, pc_d, mar_q, mar_d;
    logic [7:0] ir_q, ir_d, a_q, a_d, b_q, b_d, c_q, c_d, out_q, out_d;
    logic       carry_q, carry_d, zero_q, zero_d, bus_err_q, bus_err_d;
    ram_t       ram_q, ram_d;

    logic [7:0] alu_res;
    logic       alu_carry;
    logic [8:0] sum9;
    logic [2:0] src_cnt;

    // ALU: subtraction is A + ~B + 1, so carry out high means "no borrow".
    always_comb begin
        sum9      = {1'b0, a_q} + {1'b0, (alu_op == 2'b01) ? ~b_q : b_q} + {8'h00, (alu_op == 2'b01)};
        alu_res   = sum9[7:0];
        alu_carry = 1'b0;
        case (alu_op)
            2'b00, 2'b01: begin
                alu_res   = sum9[7:0];
                alu_carry = sum9[8];
            end
            2'b10:   alu_res = a_q & b_q;
            default: alu_res = a_q | b_q;
        endcase
    end

    // Bus resolution: the highest-priority enabled source wins, and more than one source counts as contention.
    always_comb begin
        src_cnt = 3'(eu) + 3'(ea) + 3'(eb) + 3'(ec) + 3'(!ei_n) + 3'(!ce_n) + 3'(ep);
        if (eu)         wbus = alu_res;
        else if (ea)    wbus = a_q;
        else if (eb)    wbus = b_q;
        else if (ec)    wbus = c_q;
        else if (!ei_n) wbus = {4'h0, ir_q[3:0]};
        else if (!ce_n) wbus = ram_q[mar_q];
        else if (ep)    wbus = {4'h0, pc_q};
        else            wbus = 8'h00;
    end

    // Next-state: every active load strobe samples the pre-edge bus, and the PC counts only when it is not driving the bus.
    always_comb begin
        pc_d      = pc_q;
        mar_d     = mar_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        out_d     = out_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        bus_err_d = bus_err_q | (src_cnt > 3'd1);
        ram_d     = ram_q;
        if (cp && !ep) pc_d = pc_q + 4'd1;
        if (!lm_n)     mar_d = wbus[3:0];
        if (!li_n)     ir_d = wbus;
        if (!la_n)     a_d = wbus;
        if (!lb_n)     b_d = wbus;
        if (!lc_n)     c_d = wbus;
        if (!lo_n)     out_d = wbus;
        if (!la_n && eu) begin
            carry_d = alu_carry;
            zero_d  = (wbus == 8'h00);
        end
        if (prog_we)   ram_d[prog_addr] = prog_data;
    end

    // State registers: reset clears everything except RAM, which simply holds (so load-port writes are dropped during reset).
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            pc_q      <= 4'h0;
            mar_q     <= 4'h0;
            ir_q      <= 8'h00;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            c_q       <= 8'h00;
            out_q     <= 8'h00;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            out_q     <= out_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            bus_err_q <= bus_err_d;
            ram_q     <= ram_d;
        end
    end

    assign opcode  = ir_q[7:4];
    assign out_reg = out_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath: microcode words with hand-computed results.
module tb_sap_datapath;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [15:0] con;
    logic [3:0]  opcode;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [7:0]  out_reg;
    logic [7:0]  wbus;
    logic        carry, zero, bus_err;

    int n_compared = 0;
    int n_mismatched = 0;

    localparam logic [15:0] IDLE   = 16'h3E07;
    localparam logic [15:0] SHOW_A = 16'h3F07;
    localparam logic [15:0] SHOW_B = 16'h3E87;
    localparam logic [15:0] SHOW_C = 16'h3E47;
    localparam logic [15:0] SHOW_P = 16'h7E07;
    localparam logic [15:0] SHOW_I = 16'h3A07;
    localparam logic [15:0] SHOW_M = 16'h2E07;

    sap_datapath dut (
        .CLK(CLK), .CLR(CLR), .con(con), .opcode(opcode),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .out_reg(out_reg), .wbus(wbus), .carry(carry), .zero(zero), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic [15:0] w);
        @(negedge CLK);
        con = w;
        @(posedge CLK);
        #1;
    endtask

    task automatic show(input logic [15:0] w);
        con = w;
        #1;
    endtask

    task automatic set_mem(input logic [3:0] addr, input logic [7:0] data);
        @(negedge CLK);
        con = IDLE;
        prog_we = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge CLK);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b0; con = IDLE; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
        #1;
        n_compared++; if (out_reg !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_out got %h want 00", out_reg); end
        n_compared++; if ({carry, zero, bus_err} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags got %b want 000", {carry, zero, bus_err}); end
        n_compared++; if (wbus !== 8'h00) begin n_mismatched++; $display("[TB] FAIL idle_bus got %h want 00", wbus); end
        show(SHOW_A);
        n_compared++; if (wbus !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_a got %h want 00", wbus); end
        @(negedge CLK); CLR = 1'b1; con = IDLE;
    endtask

    task automatic test_fetch();
        set_mem(4'h0, 8'h09);
        set_mem(4'h9, 8'h2A);
        set_mem(4'hA, 8'hE0);
        step(16'h5E07); step(16'hBE07); step(16'h2607); step(16'h1A07); step(16'h2C07);
        n_compared++; if (opcode !== 4'h0) begin n_mismatched++; $display("[TB] FAIL fetch_opcode got %h want 0", opcode); end
        show(SHOW_I);
        n_compared++; if (wbus !== 8'h09) begin n_mismatched++; $display("[TB] FAIL fetch_ir_low got %h want 09", wbus); end
        show(SHOW_A);
        n_compared++; if (wbus !== 8'h2A) begin n_mismatched++; $display("[TB] FAIL fetch_a got %h want 2a", wbus); end
        show(SHOW_P);
        n_compared++; if (wbus !== 8'h01) begin n_mismatched++; $display("[TB] FAIL fetch_pc got %h want 01", wbus); end
    endtask

    task automatic test_add();
        step(16'h1F07); step(16'h2E03); step(16'h3C0F);
        show(SHOW_B);
        n_compared++; if (wbus !== 8'hE0) begin n_mismatched++; $display("[TB] FAIL add_b got %h want e0", wbus); end
        show(SHOW_A);
        n_compared++; if (wbus !== 8'h0A) begin n_mismatched++; $display("[TB] FAIL add_a got %h want 0a", wbus); end
        n_compared++; if ({carry, zero} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL add_flags got %b want 10", {carry, zero}); end
    endtask

    task automatic test_sub();
        set_mem(4'hA, 8'h05); step(16'h2C07); step(16'h2E03); step(16'h3C1F);
        show(SHOW_A);
        n_compared++; if (wbus !== 8'h00) begin n_mismatched++; $display("[TB] FAIL sub_zero_a got %h want 00", wbus); end
        n_compared++; if ({carry, zero} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL sub_zero_flags got %b want 11", {carry, zero}); end
        set_mem(4'hA, 8'h03); step(16'h2C07);
        set_mem(4'hA, 8'h05); step(16'h2E03); step(16'h3C1F);
        show(SHOW_A);
        n_compared++; if (wbus !== 8'hFE) begin n_mismatched++; $display("[TB] FAIL sub_borrow_a got %h want fe", wbus); end
        n_compared++; if ({carry, zero} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL sub_borrow_flags got %b want 00", {carry, zero}); end
    endtask

    task automatic test_swap_out();
        set_mem(4'hA, 8'h11); step(16'h2C07);
        set_mem(4'hA, 8'h22); step(16'h2E03);
        step(16'h3F05); step(16'h3C87); step(16'h3E43);
        show(SHOW_C);
        n_compared++; if (wbus !== 8'h11) begin n_mismatched++; $display("[TB] FAIL swap_c got %h want 11", wbus); end
        show(SHOW_A);
        n_compared++; if (wbus !== 8'h22) begin n_mismatched++; $display("[TB] FAIL swap_a got %h want 22", wbus); end
        show(SHOW_B);
        n_compared++; if (wbus !== 8'h11) begin n_mismatched++; $display("[TB] FAIL swap_b got %h want 11", wbus); end
        step(16'h3F06);
        n_compared++; if (out_reg !== 8'h22) begin n_mismatched++; $display("[TB] FAIL out_load got %h want 22", out_reg); end
    endtask

    task automatic test_read_before_write();
        set_mem(4'hA, 8'h5C);
        @(negedge CLK);
        prog_we = 1'b1; prog_addr = 4'hA; prog_data = 8'h77; con = 16'h2C07;
        #1;
        n_compared++; if (wbus !== 8'h5C) begin n_mismatched++; $display("[TB] FAIL rbw_bus got %h want 5c", wbus); end
        @(posedge CLK); #1;
        prog_we = 1'b0;
        show(SHOW_A);
        n_compared++; if (wbus !== 8'h5C) begin n_mismatched++; $display("[TB] FAIL rbw_a got %h want 5c", wbus); end
        show(SHOW_M);
        n_compared++; if (wbus !== 8'h77) begin n_mismatched++; $display("[TB] FAIL rbw_ram got %h want 77", wbus); end
    endtask

    task automatic test_pc_wrap();
        for (int i = 0; i < 14; i++) step(16'hBE07);
        show(SHOW_P);
        n_compared++; if (wbus !== 8'h0F) begin n_mismatched++; $display("[TB] FAIL pc_max got %h want 0f", wbus); end
        step(16'hBE07);
        show(SHOW_P);
        n_compared++; if (wbus !== 8'h00) begin n_mismatched++; $display("[TB] FAIL pc_wrap got %h want 00", wbus); end
        step(16'hFE07);
        show(SHOW_P);
        n_compared++; if (wbus !== 8'h00) begin n_mismatched++; $display("[TB] FAIL pc_cp_with_ep got %h want 00", wbus); end
    endtask

    task automatic test_bus_contention();
        n_compared++; if (bus_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bus_err_clean got %b want 0", bus_err); end
        @(negedge CLK);
        con = 16'h3F87;
        #1;
        n_compared++; if (wbus !== 8'h5C) begin n_mismatched++; $display("[TB] FAIL contention_bus got %h want 5c", wbus); end
        @(posedge CLK); #1;
        n_compared++; if (bus_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bus_err_set got %b want 1", bus_err); end
        show(16'h3F8F);
        n_compared++; if (wbus !== 8'h6D) begin n_mismatched++; $display("[TB] FAIL alu_priority got %h want 6d", wbus); end
        step(IDLE); step(IDLE);
        n_compared++; if (bus_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bus_err_sticky got %b want 1", bus_err); end
    endtask

    task automatic test_reset_midinstr();
        step(16'h1F07); step(16'h2E03);
        @(negedge CLK);
        con = 16'h3C0F;
        #2;
        CLR = 1'b0;
        #1;
        n_compared++; if ({out_reg, carry, zero, bus_err, opcode} !== 15'h0) begin n_mismatched++; $display("[TB] FAIL midreset_outputs got %h want 0", {out_reg, carry, zero, bus_err, opcode}); end
        show(SHOW_A);
        n_compared++; if (wbus !== 8'h00) begin n_mismatched++; $display("[TB] FAIL midreset_a got %h want 00", wbus); end
        show(SHOW_B);
        n_compared++; if (wbus !== 8'h00) begin n_mismatched++; $display("[TB] FAIL midreset_b got %h want 00", wbus); end
        @(negedge CLK);
        prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'hFF; con = 16'hBE07;
        @(posedge CLK); #1;
        prog_we = 1'b0;
        show(SHOW_P);
        n_compared++; if (wbus !== 8'h00) begin n_mismatched++; $display("[TB] FAIL held_pc got %h want 00", wbus); end
        @(negedge CLK);
        CLR = 1'b1;
        show(SHOW_M);
        n_compared++; if (wbus !== 8'h09) begin n_mismatched++; $display("[TB] FAIL ram_kept got %h want 09", wbus); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_add();
        test_sub();
        test_swap_out();
        test_read_before_write();
        test_pc_wrap();
        test_bus_contention();
        test_reset_midinstr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
